// File: rtl/axi_std_master.sv
// AXI4 master issuing one INCR burst at a time from/to a local beat buffer.
// Ports: host cmd_*/buf_*/done/err, AXI4 AW/W/B/AR/R master channels.
module axi_std_master #(
    parameter int  C_M_AXI_ID_WIDTH   = 1,
    parameter int  C_M_AXI_DATA_WIDTH = 512,
    parameter int  C_M_AXI_ADDR_WIDTH = 10,
    parameter int  BUF_DEPTH          = 16,
    localparam int IDX_W    = $clog2(BUF_DEPTH),
    localparam int ADDR_LSB = $clog2(C_M_AXI_DATA_WIDTH / 8),
    localparam int DW       = C_M_AXI_DATA_WIDTH,
    localparam int AW       = C_M_AXI_ADDR_WIDTH,
    localparam int IW       = C_M_AXI_ID_WIDTH
) (
    input  logic             M_AXI_ACLK,
    input  logic             M_AXI_ARESETN,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_rw,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [IDX_W-1:0] cmd_len,
    input  logic             buf_wr_en,
    input  logic [IDX_W-1:0] buf_wr_idx,
    input  logic [DW-1:0]    buf_wr_data,
    input  logic [IDX_W-1:0] buf_rd_idx,
    output logic [DW-1:0]    buf_rd_data,
    output logic             done,
    output logic             err,
    output logic [IW-1:0]    M_AXI_AWID,
    output logic [AW-1:0]    M_AXI_AWADDR,
    output logic [7:0]       M_AXI_AWLEN,
    output logic [2:0]       M_AXI_AWSIZE,
    output logic [1:0]       M_AXI_AWBURST,
    output logic             M_AXI_AWLOCK,
    output logic [3:0]       M_AXI_AWCACHE,
    output logic [2:0]       M_AXI_AWPROT,
    output logic [3:0]       M_AXI_AWQOS,
    output logic [3:0]       M_AXI_AWREGION,
    output logic             M_AXI_AWVALID,
    input  logic             M_AXI_AWREADY,
    output logic [DW-1:0]    M_AXI_WDATA,
    output logic [DW/8-1:0]  M_AXI_WSTRB,
    output logic             M_AXI_WLAST,
    output logic             M_AXI_WVALID,
    input  logic             M_AXI_WREADY,
    input  logic [IW-1:0]    M_AXI_BID,
    input  logic [1:0]       M_AXI_BRESP,
    input  logic             M_AXI_BVALID,
    output logic             M_AXI_BREADY,
    output logic [IW-1:0]    M_AXI_ARID,
    output logic [AW-1:0]    M_AXI_ARADDR,
    output logic [7:0]       M_AXI_ARLEN,
    output logic [2:0]       M_AXI_ARSIZE,
    output logic [1:0]       M_AXI_ARBURST,
    output logic             M_AXI_ARLOCK,
    output logic [3:0]       M_AXI_ARCACHE,
    output logic [2:0]       M_AXI_ARPROT,
    output logic [3:0]       M_AXI_ARQOS,
    output logic [3:0]       M_AXI_ARREGION,
    output logic             M_AXI_ARVALID,
    input  logic             M_AXI_ARREADY,
    input  logic [IW-1:0]    M_AXI_RID,
    input  logic [DW-1:0]    M_AXI_RDATA,
    input  logic [1:0]       M_AXI_RRESP,
    input  logic             M_AXI_RLAST,
    input  logic             M_AXI_RVALID,
    output logic             M_AXI_RREADY
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_ADDR = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] WR_RESP = 3'd3;
    localparam logic [2:0] RD_ADDR = 3'd4;
    localparam logic [2:0] RD_DATA = 3'd5;
    localparam logic [2:0] DONE    = 3'd6;

    logic [2:0]       r_state;
    logic [AW-1:0]    r_addr;
    logic [IDX_W-1:0] r_len;
    logic [7:0]       r_beat;
    logic             r_err;
    logic [DW-1:0]    r_buf [BUF_DEPTH];

    logic w_cmd_acc;
    logic w_last_beat;
    logic w_w_hs;
    logic w_r_hs;
    logic w_unused;

    assign w_cmd_acc   = cmd_valid && (r_state == IDLE);
    assign w_last_beat = (r_beat == 8'(r_len));
    assign w_w_hs      = M_AXI_WVALID && M_AXI_WREADY;
    assign w_r_hs      = M_AXI_RVALID && M_AXI_RREADY;
    assign w_unused    = &{1'b0, M_AXI_BID, M_AXI_RID};

    assign cmd_ready   = (r_state == IDLE);
    assign done        = (r_state == DONE);
    assign err         = r_err;
    assign buf_rd_data = r_buf[buf_rd_idx];

    assign M_AXI_AWID     = '0;
    assign M_AXI_AWADDR   = r_addr;
    assign M_AXI_AWLEN    = 8'(r_len);
    assign M_AXI_AWSIZE   = 3'(ADDR_LSB);
    assign M_AXI_AWBURST  = 2'b01;
    assign M_AXI_AWLOCK   = 1'b0;
    assign M_AXI_AWCACHE  = 4'd0;
    assign M_AXI_AWPROT   = 3'd0;
    assign M_AXI_AWQOS    = 4'd0;
    assign M_AXI_AWREGION = 4'd0;
    assign M_AXI_AWVALID  = (r_state == WR_ADDR);

    // WDATA/WLAST depend only on the beat counter, so they hold while stalled
    assign M_AXI_WDATA  = r_buf[r_beat[IDX_W-1:0]];
    assign M_AXI_WSTRB  = '1;
    assign M_AXI_WVALID = (r_state == WR_DATA);
    assign M_AXI_WLAST  = M_AXI_WVALID && w_last_beat;
    assign M_AXI_BREADY = (r_state == WR_RESP);

    assign M_AXI_ARID     = '0;
    assign M_AXI_ARADDR   = r_addr;
    assign M_AXI_ARLEN    = 8'(r_len);
    assign M_AXI_ARSIZE   = 3'(ADDR_LSB);
    assign M_AXI_ARBURST  = 2'b01;
    assign M_AXI_ARLOCK   = 1'b0;
    assign M_AXI_ARCACHE  = 4'd0;
    assign M_AXI_ARPROT   = 3'd0;
    assign M_AXI_ARQOS    = 4'd0;
    assign M_AXI_ARREGION = 4'd0;
    assign M_AXI_ARVALID  = (r_state == RD_ADDR);
    assign M_AXI_RREADY   = (r_state == RD_DATA);

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd_acc) begin
                        r_addr  <= {cmd_addr[AW-1:ADDR_LSB],
                                    {ADDR_LSB{1'b0}}};
                        r_len   <= cmd_len;
                        r_beat  <= '0;
                        r_err   <= 1'b0;
                        r_state <= cmd_rw ? WR_ADDR : RD_ADDR;
                    end
                end
                WR_ADDR: begin
                    if (M_AXI_AWREADY) r_state <= WR_DATA;
                end
                WR_DATA: begin
                    if (w_w_hs) begin
                        r_beat <= r_beat + 8'd1;
                        if (w_last_beat) r_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        r_err   <= r_err | (M_AXI_BRESP != 2'b00);
                        r_state <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (M_AXI_ARREADY) r_state <= RD_DATA;
                end
                RD_DATA: begin
                    if (w_r_hs) begin
                        r_beat <= r_beat + 8'd1;
                        // LAST must coincide exactly with the final beat
                        r_err  <= r_err | (M_AXI_RRESP != 2'b00)
                                  | (M_AXI_RLAST != w_last_beat);
                        if (M_AXI_RLAST || w_last_beat) r_state <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Buffer is deliberately not reset; host loads only while idle
    always_ff @(posedge M_AXI_ACLK) begin
        if (buf_wr_en && (r_state == IDLE)) begin
            r_buf[buf_wr_idx] <= buf_wr_data;
        end else if (w_r_hs) begin
            r_buf[r_beat[IDX_W-1:0]] <= M_AXI_RDATA;
        end
    end

endmodule

// File: tb/tb_axi_std_master.sv
// Testbench for axi_std_master: vector table plus reset/buffer-lock sequences.
// Slave model at negedge; write beats and read data checked via queues.
module tb_axi_std_master;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_rw;
    logic [9:0]   cmd_addr;
    logic [3:0]   cmd_len;
    logic         buf_wr_en;
    logic [3:0]   buf_wr_idx;
    logic [511:0] buf_wr_data;
    logic [3:0]   buf_rd_idx;
    logic [511:0] buf_rd_data;
    logic         done;
    logic         err;
    logic [0:0]   M_AXI_AWID;
    logic [9:0]   M_AXI_AWADDR;
    logic [7:0]   M_AXI_AWLEN;
    logic [2:0]   M_AXI_AWSIZE;
    logic [1:0]   M_AXI_AWBURST;
    logic         M_AXI_AWLOCK;
    logic [3:0]   M_AXI_AWCACHE;
    logic [2:0]   M_AXI_AWPROT;
    logic [3:0]   M_AXI_AWQOS;
    logic [3:0]   M_AXI_AWREGION;
    logic         M_AXI_AWVALID;
    logic         M_AXI_AWREADY;
    logic [511:0] M_AXI_WDATA;
    logic [63:0]  M_AXI_WSTRB;
    logic         M_AXI_WLAST;
    logic         M_AXI_WVALID;
    logic         M_AXI_WREADY;
    logic [0:0]   M_AXI_BID;
    logic [1:0]   M_AXI_BRESP;
    logic         M_AXI_BVALID;
    logic         M_AXI_BREADY;
    logic [0:0]   M_AXI_ARID;
    logic [9:0]   M_AXI_ARADDR;
    logic [7:0]   M_AXI_ARLEN;
    logic [2:0]   M_AXI_ARSIZE;
    logic [1:0]   M_AXI_ARBURST;
    logic         M_AXI_ARLOCK;
    logic [3:0]   M_AXI_ARCACHE;
    logic [2:0]   M_AXI_ARPROT;
    logic [3:0]   M_AXI_ARQOS;
    logic [3:0]   M_AXI_ARREGION;
    logic         M_AXI_ARVALID;
    logic         M_AXI_ARREADY;
    logic [0:0]   M_AXI_RID;
    logic [511:0] M_AXI_RDATA;
    logic [1:0]   M_AXI_RRESP;
    logic         M_AXI_RLAST;
    logic         M_AXI_RVALID;
    logic         M_AXI_RREADY;

    axi_std_master dut (
        .M_AXI_ACLK     (clk),
        .M_AXI_ARESETN  (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rw         (cmd_rw),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .buf_wr_en      (buf_wr_en),
        .buf_wr_idx     (buf_wr_idx),
        .buf_wr_data    (buf_wr_data),
        .buf_rd_idx     (buf_rd_idx),
        .buf_rd_data    (buf_rd_data),
        .done           (done),
        .err            (err),
        .M_AXI_AWID     (M_AXI_AWID),
        .M_AXI_AWADDR   (M_AXI_AWADDR),
        .M_AXI_AWLEN    (M_AXI_AWLEN),
        .M_AXI_AWSIZE   (M_AXI_AWSIZE),
        .M_AXI_AWBURST  (M_AXI_AWBURST),
        .M_AXI_AWLOCK   (M_AXI_AWLOCK),
        .M_AXI_AWCACHE  (M_AXI_AWCACHE),
        .M_AXI_AWPROT   (M_AXI_AWPROT),
        .M_AXI_AWQOS    (M_AXI_AWQOS),
        .M_AXI_AWREGION (M_AXI_AWREGION),
        .M_AXI_AWVALID  (M_AXI_AWVALID),
        .M_AXI_AWREADY  (M_AXI_AWREADY),
        .M_AXI_WDATA    (M_AXI_WDATA),
        .M_AXI_WSTRB    (M_AXI_WSTRB),
        .M_AXI_WLAST    (M_AXI_WLAST),
        .M_AXI_WVALID   (M_AXI_WVALID),
        .M_AXI_WREADY   (M_AXI_WREADY),
        .M_AXI_BID      (M_AXI_BID),
        .M_AXI_BRESP    (M_AXI_BRESP),
        .M_AXI_BVALID   (M_AXI_BVALID),
        .M_AXI_BREADY   (M_AXI_BREADY),
        .M_AXI_ARID     (M_AXI_ARID),
        .M_AXI_ARADDR   (M_AXI_ARADDR),
        .M_AXI_ARLEN    (M_AXI_ARLEN),
        .M_AXI_ARSIZE   (M_AXI_ARSIZE),
        .M_AXI_ARBURST  (M_AXI_ARBURST),
        .M_AXI_ARLOCK   (M_AXI_ARLOCK),
        .M_AXI_ARCACHE  (M_AXI_ARCACHE),
        .M_AXI_ARPROT   (M_AXI_ARPROT),
        .M_AXI_ARQOS    (M_AXI_ARQOS),
        .M_AXI_ARREGION (M_AXI_ARREGION),
        .M_AXI_ARVALID  (M_AXI_ARVALID),
        .M_AXI_ARREADY  (M_AXI_ARREADY),
        .M_AXI_RID      (M_AXI_RID),
        .M_AXI_RDATA    (M_AXI_RDATA),
        .M_AXI_RRESP    (M_AXI_RRESP),
        .M_AXI_RLAST    (M_AXI_RLAST),
        .M_AXI_RVALID   (M_AXI_RVALID),
        .M_AXI_RREADY   (M_AXI_RREADY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit         rw;
        logic [9:0] addr;
        logic [3:0] len;
        bit         tog;
        logic [1:0] bresp;
        logic [1:0] rresp;
        int         rlast_at;
        bit         rnd_salt;
        bit         exp_err;
        logic [9:0] exp_addr;
    } vec_t;

    int n_pass;
    int n_total;

    logic [511:0] exp_w[$];
    logic [511:0] exp_r[$];

    int           step;
    int           aw_cnt;
    int           aw_step;
    int           done_step;
    logic [9:0]   cap_addr;
    logic [7:0]   cap_len;
    logic [2:0]   cap_size;
    logic [1:0]   cap_burst;
    bit           w_toggle;
    bit           w_tog;
    bit           w_hold;
    int           w_hs;
    bit           stall_prev;
    logic [511:0] stall_data;
    logic         stall_last;
    bit           b_pend;
    bit           b_hs;
    logic [1:0]   cfg_bresp;
    logic [1:0]   cfg_rresp;
    bit           r_active;
    int           r_b;
    int           rlast_at;
    logic [479:0] salt;
    int           rlast_cnt;
    bit           done_seen;
    logic         done_err;

    task automatic chk(input string nm,
                       input logic [511:0] act,
                       input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_slave();
        exp_w.delete();
        exp_r.delete();
        M_AXI_AWREADY = 1'b1;
        M_AXI_ARREADY = 1'b1;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'd0;
        M_AXI_RVALID  = 1'b0;
        M_AXI_RLAST   = 1'b0;
        M_AXI_RRESP   = 2'd0;
        M_AXI_RDATA   = '0;
        step = 0; aw_cnt = 0; aw_step = -1; done_step = -1;
        w_toggle = 0; w_tog = 1; w_hold = 0; w_hs = 0;
        stall_prev = 0; b_pend = 0; b_hs = 0;
        r_active = 0; r_b = 0; rlast_cnt = 0;
        done_seen = 0; done_err = 1'bx;
    endtask

    // One slave cycle, called at negedge; settings take effect at next posedge
    task automatic slave_step();
        logic [511:0] e;
        step++;
        if (done) begin
            done_seen = 1;
            done_step = step;
            done_err  = err;
        end
        if (M_AXI_AWVALID) begin
            aw_cnt++; aw_step = step;
            cap_addr = M_AXI_AWADDR; cap_len = M_AXI_AWLEN;
            cap_size = M_AXI_AWSIZE; cap_burst = M_AXI_AWBURST;
        end
        if (b_hs) begin M_AXI_BVALID = 0; b_hs = 0; end
        if (b_pend) begin
            M_AXI_BVALID = 1; M_AXI_BRESP = cfg_bresp; b_pend = 0;
        end
        if (M_AXI_BVALID && M_AXI_BREADY) b_hs = 1;
        M_AXI_WREADY = w_hold ? 1'b0 : (w_toggle ? w_tog : 1'b1);
        if (w_toggle) w_tog = ~w_tog;
        if (M_AXI_WVALID) begin
            if (stall_prev) begin
                chk("wdata_stable", M_AXI_WDATA, stall_data);
                chk("wlast_stable", M_AXI_WLAST, stall_last);
            end
            if (M_AXI_WREADY) begin
                stall_prev = 0;
                w_hs++;
                if (exp_w.size() == 0) begin
                    chk("w_extra_beat", 1, 0);
                end else begin
                    e = exp_w.pop_front();
                    chk("wdata", M_AXI_WDATA, e);
                    chk("wlast", M_AXI_WLAST, exp_w.size() == 0);
                end
                if (M_AXI_WLAST) b_pend = 1;
            end else begin
                stall_prev = 1;
                stall_data = M_AXI_WDATA;
                stall_last = M_AXI_WLAST;
            end
        end else stall_prev = 0;
        if (r_active) begin
            M_AXI_RVALID = 1;
            M_AXI_RDATA  = {salt, 32'(r_b)};
            M_AXI_RLAST  = (r_b == rlast_at);
            M_AXI_RRESP  = cfg_rresp;
            if (M_AXI_RREADY) begin
                exp_r.push_back(M_AXI_RDATA);
                r_b++;
                if (M_AXI_RLAST) begin
                    rlast_cnt++;
                    r_active = 0;
                end
            end
        end else begin
            M_AXI_RVALID = 0;
            M_AXI_RLAST  = 0;
        end
        if (M_AXI_ARVALID) begin
            aw_cnt++; aw_step = step;
            cap_addr = M_AXI_ARADDR; cap_len = M_AXI_ARLEN;
            cap_size = M_AXI_ARSIZE; cap_burst = M_AXI_ARBURST;
            r_active = 1; r_b = 0;
        end
    endtask

    task automatic load_buf(input int len);
        logic [511:0] d;
        for (int i = 0; i <= len; i++) begin
            @(negedge clk);
            d = rnd512();
            buf_wr_en = 1; buf_wr_idx = 4'(i); buf_wr_data = d;
            exp_w.push_back(d);
        end
        @(negedge clk);
        buf_wr_en = 0;
    endtask

    task automatic issue(input bit rw, input logic [9:0] a,
                         input logic [3:0] l);
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_rw = rw; cmd_addr = a; cmd_len = l;
        step = 0;
        @(negedge clk);
        cmd_valid = 0;
        slave_step();
    endtask

    task automatic run_to_done();
        for (int k = 0; k < 300 && !done_seen; k++) begin
            @(negedge clk);
            slave_step();
        end
        chk("done_seen", done_seen, 1);
    endtask

    task automatic run_txn(input vec_t v);
        logic [511:0] s;
        clear_slave();
        w_toggle = v.tog;
        cfg_bresp = v.bresp; cfg_rresp = v.rresp;
        rlast_at = v.rlast_at;
        s = rnd512();
        salt = v.rnd_salt ? s[479:0] : '0;
        if (v.rw) load_buf(int'(v.len));
        issue(v.rw, v.addr, v.len);
        run_to_done();
        chk("err", done_err, v.exp_err);
        chk("addr_hs_count", aw_cnt, 1);
        chk("axaddr", cap_addr, v.exp_addr);
        chk("axlen", cap_len, {4'd0, v.len});
        chk("axsize", cap_size, 3'd6);
        chk("axburst", cap_burst, 2'b01);
        if (v.rw) begin
            chk("w_handshakes", w_hs, int'(v.len) + 1);
            chk("w_queue_left", exp_w.size(), 0);
            if (!v.tog) begin
                chk("aw_latency", aw_step, 1);
                chk("done_latency", done_step, int'(v.len) + 4);
            end
        end else begin
            chk("rlast_count", rlast_cnt, 1);
        end
        @(negedge clk);
        chk("done_pulse_end", done, 0);
        chk("cmd_ready_back", cmd_ready, 1);
        if (!v.rw) begin
            for (int i = 0; exp_r.size() > 0; i++) begin
                buf_rd_idx = 4'(i);
                #1;
                chk("rd_buffer", buf_rd_data, exp_r.pop_front());
            end
        end
    endtask

    vec_t vt[7];
    vec_t v0;

    initial begin
        logic [511:0] d1;
        bit           seen;
        n_pass = 0; n_total = 0;
        rst_n = 0;
        cmd_valid = 0; cmd_rw = 0; cmd_addr = '0; cmd_len = '0;
        buf_wr_en = 0; buf_wr_idx = '0; buf_wr_data = '0;
        buf_rd_idx = '0;
        M_AXI_BID = '0; M_AXI_RID = '0;
        clear_slave();

        vt[0] = '{1'b1, 10'h040, 4'd3,  1'b0, 2'd0, 2'd0,
                  0,  1'b0, 1'b0, 10'h040};
        vt[1] = '{1'b0, 10'h000, 4'd15, 1'b0, 2'd0, 2'd0,
                  15, 1'b0, 1'b0, 10'h000};
        vt[2] = '{1'b1, 10'h100, 4'd7,  1'b1, 2'd0, 2'd0,
                  0,  1'b0, 1'b0, 10'h100};
        vt[3] = '{1'b1, 10'h200, 4'd1,  1'b0, 2'b10, 2'd0,
                  0,  1'b0, 1'b1, 10'h200};
        vt[4] = '{1'b0, 10'h0C0, 4'd5,  1'b0, 2'd0, 2'd0,
                  2,  1'b1, 1'b1, 10'h0C0};
        vt[5] = '{1'b0, 10'h3C0, 4'd2,  1'b0, 2'd0, 2'b10,
                  2,  1'b1, 1'b1, 10'h3C0};
        vt[6] = '{1'b1, 10'h07F, 4'd0,  1'b0, 2'd0, 2'd0,
                  0,  1'b0, 1'b0, 10'h040};

        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_awvalid", M_AXI_AWVALID, 0);
        chk("rst_wvalid", M_AXI_WVALID, 0);
        chk("rst_wlast", M_AXI_WLAST, 0);
        chk("rst_bready", M_AXI_BREADY, 0);
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_rready", M_AXI_RREADY, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        for (int i = 0; i < 7; i++) run_txn(vt[i]);

        // Reset pulsed in the middle of a stalled write burst
        clear_slave();
        w_toggle = 1;
        cfg_bresp = 2'd0;
        load_buf(7);
        issue(1'b1, 10'h140, 4'd7);
        for (int k = 0; k < 100 && w_hs < 3; k++) begin
            @(negedge clk);
            slave_step();
        end
        chk("mid_burst_reached", w_hs >= 3, 1);
        #2 rst_n = 0;
        #1;
        chk("arst_awvalid", M_AXI_AWVALID, 0);
        chk("arst_wvalid", M_AXI_WVALID, 0);
        chk("arst_bready", M_AXI_BREADY, 0);
        chk("arst_arvalid", M_AXI_ARVALID, 0);
        chk("arst_rready", M_AXI_RREADY, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1;
        clear_slave();
        #1;
        chk("arst_cmd_ready", cmd_ready, 1);
        v0 = '{1'b1, 10'h080, 4'd0, 1'b0, 2'd0, 2'd0,
               0, 1'b0, 1'b0, 10'h080};
        run_txn(v0);

        // Host buffer write while WDATA is being presented is ignored
        clear_slave();
        cfg_bresp = 2'd0;
        load_buf(1);
        d1 = exp_w[1];
        w_hold = 1;
        issue(1'b1, 10'h07F, 4'd1);
        seen = M_AXI_WVALID;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            slave_step();
            seen = M_AXI_WVALID;
        end
        chk("wvalid_reached", seen, 1);
        buf_wr_en = 1; buf_wr_idx = 4'd1; buf_wr_data = ~d1;
        @(negedge clk);
        buf_wr_en = 0;
        w_hold = 0;
        slave_step();
        run_to_done();
        chk("lock_err", done_err, 0);
        chk("lock_awaddr", cap_addr, 10'h040);
        chk("lock_w_hs", w_hs, 2);
        @(negedge clk);
        buf_rd_idx = 4'd1;
        #1;
        chk("lock_buffer", buf_rd_data, d1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi_std_master.md
# axi_std_master

AXI4 full-protocol master (initiator) that issues single INCR bursts, one write or one read at a time, from/to a local beat buffer. It drives a 512-bit AXI4 slave port: a host-side command interface starts each burst, and a buffer port loads write beats or unloads read beats. Only one transaction is outstanding at any time, matching the single-outstanding, read/write-serialised slave on the other end.

## Interface
- C_M_AXI_ID_WIDTH, 1, AWID/ARID width; IDs are driven to 0.
- C_M_AXI_DATA_WIDTH, 512, data beat width.
- C_M_AXI_ADDR_WIDTH, 10, byte address width.
- BUF_DEPTH, 16, beat buffer entries; power of 2, at most 256.
- M_AXI_ACLK  in  1  single clock.
- M_AXI_ARESETN  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  request a burst.
- cmd_ready  out  1  high only in IDLE.
- cmd_rw  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  start byte address; low ADDR_LSB = log2(DATA_WIDTH/8) bits forced to 0.
- cmd_len  in  log2(BUF_DEPTH)  beats minus 1 (AXI LEN encoding).
- buf_wr_en / buf_wr_idx / buf_wr_data  in  1 / log2(BUF_DEPTH) / DATA_WIDTH  host buffer load; honoured only in IDLE.
- buf_rd_idx  in  log2(BUF_DEPTH)  host buffer read index.
- buf_rd_data  out  DATA_WIDTH  combinational buffer[buf_rd_idx].
- done  out  1  one-cycle pulse at end of each transaction.
- err  out  1  valid with done: bad response or LAST mismatch.
- AW: M_AXI_AWADDR, AWLEN[7:0], AWSIZE[2:0], AWBURST[1:0], AWID, AWVALID (out); AWREADY (in).
- W: M_AXI_WDATA, WSTRB (all ones), WLAST, WVALID (out); WREADY (in).
- B: M_AXI_BREADY (out); BVALID, BRESP[1:0], BID (in).
- AR: M_AXI_ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID (out); ARREADY (in).
- R: M_AXI_RREADY (out); RVALID, RDATA, RRESP, RLAST, RID (in).
- LOCK/CACHE/PROT/QOS/REGION/USER outputs are tied to 0; user widths are 0 by default.

## Operation
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: cmd_ready=1. A cmd_valid&&cmd_ready cycle latches addr, len and rw, clears beat counter and error flag, and moves to WR_ADDR or RD_ADDR.
- WR_ADDR: AWVALID=1 with AWADDR, AWLEN = zero-extended len, AWSIZE=ADDR_LSB, AWBURST=2'b01. The AWVALID&&AWREADY handshake moves the FSM to WR_DATA.
- WR_DATA: WVALID=1, WDATA=buffer[beat], WLAST=(beat==len).
  - Each WVALID&&WREADY handshake increments beat.
  - The handshake with WLAST moves the FSM to WR_RESP.
- WR_RESP: BREADY=1. A BVALID cycle sets err if BRESP≠0, then moves to DONE.
- RD_ADDR: mirror of WR_ADDR on the AR channel; moves to RD_DATA.
- RD_DATA: RREADY=1.
  - Each RVALID cycle writes RDATA into buffer[beat] and increments beat.
  - err is set if RRESP≠0, if RLAST=1 on a beat ≠ len, or if RLAST=0 on beat==len.
  - The FSM leaves for DONE on RLAST or at beat==len, whichever comes first.
- DONE: done=1 for one cycle, then IDLE.
- VALID, once raised, is held with stable payload until its handshake completes (AXI rule).
- beat counter is 8 bits and never wraps within a legal len.

## Timing
- Reset (asynchronous, ARESETN=0): state=IDLE, all VALID/READY outputs 0, WLAST=0, done=0, err=0, cmd_ready=1 after reset release. Buffer contents are unchanged by reset.
- Reset mid-burst aborts the burst immediately; the next command starts clean.
- Latencies:
  - AWVALID/ARVALID rises the cycle after command acceptance.
  - WVALID rises the cycle after the AW handshake.
  - Back-to-back W beats run at 1 beat/cycle while WREADY=1.
- Write burst of N beats with always-ready slave: accept at T, AW at T+1, W beats T+2..T+N+1, BVALID earliest T+N+2, done one cycle after B handshake.
- Read data is visible on buf_rd_data the cycle after done.
- A buf_wr_en cycle outside IDLE is ignored. A buf_wr_en cycle in the same cycle as command acceptance is honoured.

## Test plan
- Write, len=3, addr=0x040, slave always ready:
  - Required: AWLEN=3, AWSIZE=6, AWBURST=1.
  - Required: 4 W beats buffer[0..3], WLAST only on the 4th.
  - Required: BRESP=0 gives done with err=0.
- Read, len=15, addr=0x000, RDATA=beat index:
  - Required: buffer[i]==i for i=0..15.
  - Required: done with err=0, exactly one RLAST.
- Backpressure: WREADY toggling 1/0 every cycle on an 8-beat write:
  - Required: WDATA/WLAST stable while stalled.
  - Required: exactly 8 handshakes in order.
- Error paths:
  - BRESP=2'b10 on a write gives err=1.
  - Early RLAST at beat 2 of len=5 gives err=1 and done, FSM back in IDLE.
- ARESETN pulsed low mid-W-burst:
  - Required: all VALIDs 0 asynchronously, cmd_ready=1 after release.
  - Required: a following len=0 write completes normally.
- Unaligned cmd_addr=0x07F:
  - Required: AWADDR=0x040.
  - Required: buf_wr_en during WR_DATA leaves the buffer unchanged.
